pc_sequencer: RTL

//  Fetch controller for the 32-bit pc_register. It drives pc_register.next_PC every cycle.
//  It sequences instruction-memory requests, holds the PC on stall, selects jump/branch/PC+4 redirects,
//  and diverts to a trap vector on a misaligned target or a fetch timeout.
//  It sits between pc_register, instruction memory and the decode/execute stage.

---
 rtl/pc_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch sequencer for pc_register: boot, fetch with timeout, execute redirect, trap vectoring.
// Define PC_SEQ_PERF_EN to build the retired-instruction counter; otherwise instr_count is tied to zero.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0080,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] next_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] epc,
  output logic [31:0] instr_count
);

  // state   | meaning
  // S_BOOT  | drive RESET_VECTOR into pc_register
  // S_REQ   | fetch request outstanding at PC, timeout counter running
  // S_EXEC  | instr valid; redirect or hold on stall
  // S_TRAP  | one-cycle trap pulse, redirect to TRAP_VECTOR
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_EXEC, S_TRAP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_instr;
  logic [1:0]  r_cause;
  logic [31:0] r_epc;

  logic [31:0] w_target;
  logic        w_misaligned;
  logic        w_timeout;
  logic        w_retire;

  assign w_target     = jump ? jump_target : (branch_taken ? branch_target : PC + 32'd4);
  assign w_misaligned = |w_target[1:0];
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST) && !imem_ack;
  assign w_retire     = !reset && (r_state == S_EXEC) && !stall && !w_misaligned;

  // Strobes are gated by reset so a request in flight is dropped the same cycle.
  assign imem_req    = !reset && (r_state == S_REQ);
  assign imem_addr   = imem_req ? PC : 32'h0;
  assign instr_valid = !reset && (r_state == S_EXEC);
  assign trap        = !reset && (r_state == S_TRAP);
  assign instr       = r_instr;
  assign trap_cause  = r_cause;
  assign epc         = r_epc;

  always_comb begin
    next_PC = PC;
    if (reset) begin
      next_PC = RESET_VECTOR;
    end else begin
      case (r_state)
        S_BOOT:  next_PC = RESET_VECTOR;
        S_REQ:   next_PC = PC;
        S_EXEC:  if (!stall && !w_misaligned) next_PC = w_target;
        S_TRAP:  next_PC = TRAP_VECTOR;
        default: next_PC = PC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_cnt   <= 8'd0;
      r_instr <= 32'h0;
      r_cause <= 2'b00;
      r_epc   <= 32'h0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_cnt   <= 8'd0;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_cnt   <= 8'd0;
            r_state <= S_EXEC;
          end else if (w_timeout) begin
            r_cause <= 2'b10;
            r_epc   <= PC;
            r_cnt   <= 8'd0;
            r_state <= S_TRAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            if (w_misaligned) begin
              r_cause <= 2'b01;
              r_epc   <= PC;
              r_state <= S_TRAP;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_TRAP:  r_state <= S_REQ;
        default: r_state <= S_BOOT;
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) r_count <= 32'h0;
    else if (w_retire) r_count <= r_count + 32'd1;
  end

  assign instr_count = r_count;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign instr_count     = 32'h0;
`endif

endmodule
